// File: rtl/core_ctrl.sv
// Multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP) with a memory-response timeout.
// Strobes decode from the current state; ir_we and EXEC pc_sel follow their inputs combinationally.
module core_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_rvalid,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_rvalid,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NONE,
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_LUI
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Counter value in the last cycle a FETCH/MEM may wait before trapping.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     cur;
  state_t     nxt;
  cls_t       cls;
  logic [7:0] tmo_cnt;
  logic       tmo_last;
  logic [3:0] dec_alu_op;
  logic       dec_src_imm;
  logic       rd_nonzero;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^{instr[31], instr[29:15]};
  assign tmo_last          = (tmo_cnt == TMO_LAST);
  assign rd_nonzero        = (instr[11:7] != 5'd0);
  assign state             = cur;

  always_comb begin
    cls = C_NONE;
    case (instr[6:0])
      OP_R:      cls = C_R;
      OP_I:      cls = C_I;
      OP_LOAD:   cls = C_LOAD;
      OP_STORE:  cls = C_STORE;
      OP_BRANCH: cls = C_BRANCH;
      OP_JAL:    cls = C_JAL;
      OP_LUI:    cls = C_LUI;
      default:   cls = C_NONE;
    endcase
  end

  // Shift-right-arithmetic is the only I-ALU op that takes instr[30].
  always_comb begin
    dec_alu_op  = 4'b0000;
    dec_src_imm = 1'b1;
    case (cls)
      C_R: begin
        dec_alu_op  = {instr[30], instr[14:12]};
        dec_src_imm = 1'b0;
      end
      C_I:      dec_alu_op = {(instr[14:12] == 3'b101) & instr[30], instr[14:12]};
      C_BRANCH: begin
        dec_alu_op  = 4'b1000;
        dec_src_imm = 1'b0;
      end
      C_NONE:   dec_src_imm = 1'b0;
      default:  dec_alu_op = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur         <= S_IDLE;
      tmo_cnt     <= 8'd0;
      alu_op      <= 4'b0000;
      alu_src_imm <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur) begin
        tmo_cnt <= 8'd0;
      end else if (cur == S_FETCH || cur == S_MEM) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (cur == S_DECODE) begin
        alu_op      <= dec_alu_op;
        alu_src_imm <= dec_src_imm;
      end
    end
  end

  always_comb begin
    nxt      = cur;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'b00;
    trap     = 1'b0;
    case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (tmo_last) begin
          nxt = S_TRAP;
        end
      end
      S_DECODE: nxt = (cls == C_NONE) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: nxt = S_MEM;
          C_BRANCH: begin
            pc_we  = 1'b1;
            pc_sel = branch_taken;
            nxt    = S_FETCH;
          end
          C_NONE:  nxt = S_TRAP;
          default: nxt = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (dmem_rvalid) begin
          if (cls == C_STORE) begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (tmo_last) begin
          nxt = S_TRAP;
        end
      end
      S_WB: begin
        pc_we  = 1'b1;
        rf_we  = rd_nonzero;
        pc_sel = (cls == C_JAL);
        wb_sel = (cls == C_LOAD) ? 2'b01 : (cls == C_JAL) ? 2'b10 : 2'b00;
        nxt    = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: nxt = S_TRAP;
    endcase
  end

  trap_is_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    (cur == S_TRAP) |-> !(imem_req || dmem_req || ir_we || pc_we || rf_we));

  tmo_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    tmo_cnt <= TMO_LAST);

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized scoreboard bench for core_ctrl: a memory-model driver pushes expected retire/trap
// events from a spec-level model; a negedge monitor pops and compares as the DUT produces them.
module tb_core_ctrl;

  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_req;
  logic        imem_rvalid;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_rvalid;
  logic        branch_taken;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        rf_we;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [2:0]  state;

  core_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .imem_req(imem_req), .imem_rvalid(imem_rvalid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_rvalid(dmem_rvalid),
    .branch_taken(branch_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .wb_sel(wb_sel),
    .trap(trap), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_trap;
    int         cyc;
    int         ir_cnt;
    bit         pc_sel;
    bit         rf;
    bit         chk_wb;
    logic [1:0] wb;
    logic [3:0] aop;
    bit         src;
    int         mem_cnt;
    bit         mem_we;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] legal_ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110111};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bail(input string what);
    checks++;
    errors++;
    $display("FAIL %s: expected handshake never arrived", what);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    #600000;
    bail("watchdog");
  end

  // Reference: f = FETCH cycles incl. the response cycle (0 = never answers),
  // m = MEM cycles incl. completion (0 = never). kind: 0 retire, 1 retire via MEM,
  // 2 trap before EXEC, 3 trap in MEM. Cycle 1 is the first FETCH cycle.
  task automatic model(input logic [31:0] ins, input int f, input int m, input bit bt,
                       output exp_t e, output int kind);
    logic [6:0] opc;
    logic [2:0] f3;
    bit is_r, is_i, is_l, is_s, is_b, is_j, is_u, rd_nz;
    opc = ins[6:0];
    f3  = ins[14:12];
    rd_nz = (ins[11:7] != 5'd0);
    is_r = (opc == 7'b0110011); is_i = (opc == 7'b0010011);
    is_l = (opc == 7'b0000011); is_s = (opc == 7'b0100011);
    is_b = (opc == 7'b1100011); is_j = (opc == 7'b1101111);
    is_u = (opc == 7'b0110111);
    e.is_trap = 0; e.cyc = 0; e.pc_sel = 0; e.rf = 0; e.chk_wb = 0; e.wb = 2'b00;
    e.aop = 4'b0000; e.src = 0; e.mem_cnt = 0; e.mem_we = 0;
    e.ir_cnt = (f == 0) ? 0 : 1;
    kind = 0;
    if (f == 0) begin
      e.is_trap = 1; e.cyc = T + 1; kind = 2;
    end else if (!(is_r || is_i || is_l || is_s || is_b || is_j || is_u)) begin
      e.is_trap = 1; e.cyc = f + 2; kind = 2;
    end else begin
      if (is_r)      e.aop = {ins[30], f3};
      else if (is_i) e.aop = {(f3 == 3'b101) & ins[30], f3};
      else if (is_b) e.aop = 4'b1000;
      e.src = !(is_r || is_b);
      if (is_l || is_s) begin
        if (m == 0) begin
          e.is_trap = 1; e.cyc = f + 3 + T; kind = 3;
        end else begin
          kind = 1;
          e.mem_cnt = m;
          e.mem_we  = is_s;
          e.cyc     = is_s ? f + 2 + m : f + 3 + m;
          e.rf      = is_l && rd_nz;
          e.chk_wb  = is_l;
          e.wb      = 2'b01;
        end
      end else if (is_b) begin
        e.cyc = f + 2; e.pc_sel = bt;
      end else begin
        e.cyc = f + 3; e.pc_sel = is_j; e.rf = rd_nz; e.chk_wb = 1;
        e.wb = is_j ? 2'b10 : 2'b00;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 0; imem_rvalid = 1; dmem_rvalid = 1; instr = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
                          alu_op, alu_src_imm, wb_sel, trap, state}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1; imem_rvalid = 0; dmem_rvalid = 0;
    @(negedge clk);
    chk("idle_after_release", {state, imem_req}, {3'd0, 1'b0});
    @(posedge clk); #1;
    chk("fetch_after_idle", {state, imem_req}, {3'd1, 1'b1});
  endtask

  task automatic wait_imem();
    int n = 0;
    while (!imem_req) begin
      if (n == 40) bail("wait_imem_req");
      imem_rvalid = 1'($urandom);
      dmem_rvalid = dmem_req ? 1'b0 : 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    imem_rvalid = 0; dmem_rvalid = 0;
  endtask

  task automatic wait_dmem();
    int n = 0;
    while (!dmem_req) begin
      if (n == 40) bail("wait_dmem_req");
      imem_rvalid = imem_req ? 1'b0 : 1'($urandom);
      dmem_rvalid = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    imem_rvalid = 0; dmem_rvalid = 0;
  endtask

  task automatic hold_and_reset();
    repeat (22) begin
      imem_rvalid = 1'($urandom);
      dmem_rvalid = 1'($urandom);
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic run_instr(input logic [31:0] ins, input int f, input int m,
                           input bit bt, input bit abort);
    exp_t e;
    int kind;
    model(ins, f, m, bt, e, kind);
    wait_imem();
    if (!(abort && kind == 1)) q.push_back(e);
    branch_taken = bt;
    for (int k = 1; k <= ((f == 0) ? T : f); k++) begin
      dmem_rvalid = 1'($urandom);
      if (k == f) begin
        imem_rvalid = 1; instr = ins;
      end else begin
        imem_rvalid = 0; instr = $urandom;
      end
      @(posedge clk); #1;
    end
    imem_rvalid = 0; dmem_rvalid = 0;
    if (kind == 2) begin
      hold_and_reset();
    end else if (kind == 1 || kind == 3) begin
      wait_dmem();
      if (abort && kind == 1) begin
        @(posedge clk); #1;
        do_reset();
      end else begin
        for (int k = 1; k <= ((m == 0) ? T : m); k++) begin
          imem_rvalid = 1'($urandom);
          dmem_rvalid = (k == m);
          @(posedge clk); #1;
        end
        imem_rvalid = 0; dmem_rvalid = 0;
        if (kind == 3) hold_and_reset();
      end
    end
  endtask

  // Monitor: tracks one instruction from its first FETCH cycle to its retire or trap.
  bit in_instr = 0;
  bit trapped = 0;
  bit stray_rf = 0;
  bit mem_we_seen = 0;
  int cyc = 0;
  int mem_cnt = 0;
  int ir_cnt = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      in_instr = 0; trapped = 0;
    end else if (trapped) begin
      chk("trap_sticky", {trap, imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, state},
          {7'b1000000, 3'd6});
    end else begin
      if (imem_req && !in_instr) begin
        in_instr = 1; cyc = 0; mem_cnt = 0; ir_cnt = 0; mem_we_seen = 0; stray_rf = 0;
      end
      if (in_instr) begin
        cyc++;
        if (dmem_req) begin
          mem_cnt++;
          mem_we_seen = mem_we_seen | dmem_we;
        end
        if (ir_we) ir_cnt++;
        if (rf_we && !pc_we) stray_rf = 1;
        if (pc_we || trap) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event pc_we=%0b trap=%0b with empty scoreboard", pc_we, trap);
          end else begin
            e = q.pop_front();
            chk("event_is_trap", trap, e.is_trap);
            chk("cycles_from_fetch", cyc, e.cyc);
            chk("ir_we_count", ir_cnt, e.ir_cnt);
            if (!e.is_trap) begin
              chk("pc_sel", pc_sel, e.pc_sel);
              chk("rf_we", rf_we, e.rf);
              chk("alu_op", alu_op, e.aop);
              chk("alu_src_imm", alu_src_imm, e.src);
              chk("mem_cycles", mem_cnt, e.mem_cnt);
              chk("dmem_we", mem_we_seen, e.mem_we);
              chk("rf_we_outside_wb", stray_rf, 0);
              if (e.chk_wb) chk("wb_sel", wb_sel, e.wb);
            end
          end
          in_instr = 0;
          if (trap) trapped = 1;
        end
      end else begin
        chk("idle_quiet", {imem_req, dmem_req, ir_we, pc_we, rf_we, trap, state}, 32'd0);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] ins;
    int f, m;
    rst_n = 0; instr = 0; imem_rvalid = 0; dmem_rvalid = 0; branch_taken = 0;
    do_reset();

    run_instr(32'h403100B3, 2, 1, 0, 0);   // sub x1,x2,x3
    run_instr(32'h0000A283, 1, 3, 0, 0);   // lw x5,0(x1)
    run_instr(32'h00208463, 1, 1, 1, 0);   // beq taken
    run_instr(32'h00208463, 3, 1, 0, 0);   // beq not taken
    run_instr(32'h00000013, 1, 1, 1, 0);   // addi x0,x0,0
    run_instr(32'h008000EF, 1, 1, 0, 0);   // jal x1,8
    run_instr(32'h4050D093, 2, 1, 0, 0);   // srai x1,x1,5
    run_instr(32'h123450B7, 1, 1, 0, 0);   // lui x1
    run_instr(32'h0050A023, T, T, 0, 0);   // sw, responses in the final allowed cycle
    run_instr(32'h0000A283, 1, 2, 0, 1);   // lw aborted by reset mid-MEM
    run_instr(32'h00000000, 1, 1, 0, 0);   // illegal opcode
    run_instr(32'h403100B3, 0, 1, 0, 0);   // fetch never answers
    run_instr(32'h0000A283, 2, 0, 0, 0);   // load never completes

    for (int i = 0; i < 250; i++) begin
      ins = $urandom;
      if ($urandom_range(99) < 90) ins[6:0] = legal_ops[$urandom_range(6)];
      f = ($urandom_range(19) == 0) ? 0 : $urandom_range(T, 1);
      m = ($urandom_range(19) == 0) ? 0 : $urandom_range(T, 1);
      run_instr(ins, f, m, 1'($urandom), $urandom_range(29) == 0);
    end

    wait_imem();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
